// File: rtl/alu_seq_ctrl.sv
// Wide ALU sequencer: runs an NWORDS x 4-bit operation through one shared
// alu_4bit slice, least-significant nibble first, chaining carry between cycles.
module alu_seq_ctrl #(
  parameter int NWORDS = 4,
  parameter int IDXW   = 4,
  localparam int W     = 4 * NWORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_op,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z,
  output logic         out_cout,
  output logic         out_zero,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_cin,
  output logic [1:0]   alu_sop,
  input  logic [3:0]   alu_z,
  input  logic         alu_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, z_q, z_d;
  logic [1:0]      op_q, op_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            zero_q, zero_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW+1:0] base;

  // Bit offset of the nibble currently on the slice.
  assign base = {idx_q, 2'b00};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    op_d    = op_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    idx_d   = idx_q;
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_cin = 1'b0;
    alu_sop = 2'b00;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          carry_d = in_op[1] & in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        alu_a   = 4'(a_q >> base);
        alu_b   = 4'(b_q >> base);
        alu_sop = op_q;
        alu_cin = op_q[1] & carry_q;
        z_d     = (z_q & ~(W'(4'hF) << base)) | (W'(alu_z) << base);
        carry_d = alu_cout;
        if (idx_q == IDXW'(NWORDS - 1)) begin
          cout_d  = op_q[1] & alu_cout;
          zero_d  = (z_d == '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      op_q    <= 2'b00;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_z     = z_q;
  assign out_cout  = cout_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural alu_4bit slice plus a whole-word
// arithmetic reference; directed cases followed by random operations.
module tb_alu_seq_ctrl;
  localparam int NW = 4;
  localparam int W  = 4 * NW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [1:0]   in_op;
  logic         in_cin;
  logic         out_valid, out_ready;
  logic [W-1:0] out_z;
  logic         out_cout, out_zero;
  logic [3:0]   alu_a, alu_b, alu_z;
  logic         alu_cin, alu_cout;
  logic [1:0]   alu_sop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NWORDS(NW), .IDXW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cout(out_cout), .out_zero(out_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sop(alu_sop),
    .alu_z(alu_z), .alu_cout(alu_cout)
  );

  // External 4-bit slice
  always_comb begin
    logic [4:0] s;
    logic [3:0] nb;
    nb = ~alu_b;
    s  = 5'h00;
    case (alu_sop)
      2'b00:   s = {1'b0, ~(alu_a & alu_b)};
      2'b01:   s = {1'b0, ~(alu_a | alu_b)};
      2'b10:   s = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
      default: s = 5'(alu_a) + 5'(nb) + 5'(alu_cin);
    endcase
    alu_z    = s[3:0];
    alu_cout = s[4];
  end

  function automatic logic [W:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, b,
                                        input logic cin);
    logic [W-1:0] nb;
    nb = ~b;
    case (op)
      2'b00:   return {1'b0, ~(a & b)};
      2'b01:   return {1'b0, ~(a | b)};
      2'b10:   return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      default: return {1'b0, a} + {1'b0, nb} + (W+1)'(cin);
    endcase
  endfunction

  // Carry entering nibble k: carry out of the low 4k bits of the whole-word sum.
  function automatic logic cin_at(input logic [1:0] op, input logic [W-1:0] a, b,
                                  input logic cin, input int k);
    logic [W:0]   mask, s;
    logic [W-1:0] bb;
    if (!op[1]) return 1'b0;
    bb   = op[0] ? ~b : b;
    mask = ((W+1)'(1) << (4 * k)) - (W+1)'(1);
    s    = ({1'b0, a} & mask) + ({1'b0, bb} & mask) + (W+1)'(cin);
    return 1'(s >> (4 * k));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge. hold = DONE cycles with out_ready low;
  // queue presents the next request during the hold.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b, input logic cin,
                        input int hold, input bit queue, input logic [1:0] qop,
                        input logic [W-1:0] qa, qb, input logic qcin);
    logic [W:0] exp;
    int lat, k, cnt;
    exp       = ref_op(op, a, b, cin);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    out_ready = (hold == 0);
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_op    = 2'($urandom);
    in_cin   = 1'($urandom);
    lat = 1;
    k   = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      if (k < NW) begin
        chk("alu_a",   32'(alu_a),   32'(4'(a >> (4 * k))));
        chk("alu_b",   32'(alu_b),   32'(4'(b >> (4 * k))));
        chk("alu_sop", 32'(alu_sop), 32'(op));
        chk("alu_cin", 32'(alu_cin), 32'(cin_at(op, a, b, cin, k)));
        chk("run_in_ready", 32'(in_ready), 32'd0);
      end
      k++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(NW + 1));
    for (int d = 0; d < hold; d++) begin
      if (queue) begin
        in_valid = 1'b1;
        in_op    = qop;
        in_a     = qa;
        in_b     = qb;
        in_cin   = qcin;
      end
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_z", 32'(out_z), 32'(exp[W-1:0]));
      @(negedge clk);
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_z", 32'(out_z), 32'(exp[W-1:0]));
    chk("out_cout", 32'(out_cout), 32'(exp[W]));
    chk("out_zero", 32'(out_zero), 32'(exp[W-1:0] == '0));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_z_hold", 32'(out_z), 32'(exp[W-1:0]));
    chk("idle_alu_a", 32'(alu_a), 32'd0);
    chk("idle_alu_sop", 32'(alu_sop), 32'd0);
    chk("idle_alu_cin", 32'(alu_cin), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'b00;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z", 32'(out_z), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_alu_sop", 32'(alu_sop), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b10, 16'h1234, 16'h0FFF, 1'b0, 0, 1'b0, 2'b00, '0, '0, 1'b0);
    run_op(2'b10, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 2'b00, '0, '0, 1'b0);
    run_op(2'b11, 16'h0005, 16'h0003, 1'b1, 0, 1'b0, 2'b00, '0, '0, 1'b0);
    run_op(2'b11, 16'h0003, 16'h0005, 1'b1, 0, 1'b0, 2'b00, '0, '0, 1'b0);
    run_op(2'b00, 16'hF0F0, 16'hFF00, 1'b1, 0, 1'b0, 2'b00, '0, '0, 1'b0);
    run_op(2'b01, 16'h00F0, 16'h0F00, 1'b1, 0, 1'b0, 2'b00, '0, '0, 1'b0);

    // Backpressure with a request waiting; it must be taken right after IDLE.
    run_op(2'b10, 16'hA5A5, 16'h1111, 1'b0, 5, 1'b1, 2'b11, 16'h4000, 16'h0001, 1'b1);
    run_op(2'b11, 16'h4000, 16'h0001, 1'b1, 0, 1'b0, 2'b00, '0, '0, 1'b0);

    // Reset while nibble 2 is on the slice
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_a     = 16'h3333;
    in_b     = 16'h1111;
    in_cin   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_alu_a", 32'(alu_a), 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_z", 32'(out_z), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b10, 16'h0001, 16'h0001, 1'b0, 0, 1'b0, 2'b00, '0, '0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rb  = (i % 6 == 5) ? ~ra : W'($urandom);
      run_op(rop, ra, rb, 1'($urandom), $urandom_range(0, 2), 1'b0, 2'b00, '0, '0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencer that performs wide (NWORDS×4-bit) ALU operations by time-multiplexing one external alu_4bit slice, least-significant nibble first.
- Arithmetic ops chain the carry between cycles through a register.
- The block sits between a requester (valid/ready operand interface) and the shared alu_4bit.
- It owns the slice's a/b/cin/s_op inputs and captures its z/cout outputs.

Parameters:
NWORDS, 4, number of 4-bit slices per operation; operand width W = 4*NWORDS; legal range 1..16.
IDXW, 4, width of slice index counter; must satisfy 2^IDXW >= NWORDS.

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  request: operands/op valid
in_ready  out  1  controller can accept a request
in_a  in  W  operand A
in_b  in  W  operand B
in_op  in  2  op code: 00 NAND, 01 NOR, 10 ADD, 11 SUB
in_cin  in  1  carry into slice 0 (arith ops only)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_z  out  W  result
out_cout  out  1  carry out of top slice (arith ops); 0 for logic ops
out_zero  out  1  1 when out_z == 0
alu_a  out  4  to alu_4bit a
alu_b  out  4  to alu_4bit b
alu_cin  out  1  to alu_4bit cin
alu_sop  out  2  to alu_4bit s_op
alu_z  in  4  from alu_4bit z
alu_cout  in  1  from alu_4bit cout

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - in_ready=1, out_valid=0.
  - out_z, out_cout, out_zero, carry register and index all go to 0.
  - Reset overrides every other input, including mid-RUN or in DONE with out_valid high; any in-flight operation is discarded.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE), registered. out_valid = (state==DONE), registered.
- IDLE:
  - On in_valid && in_ready: latch in_a, in_b, in_op.
  - Carry register := in_cin for op 1x, 0 for op 0x.
  - idx := 0; go to RUN.
- RUN (combinational drive of the slice):
  - alu_a = A[4*idx+3:4*idx], alu_b = B[4*idx+3:4*idx], alu_sop = latched op.
  - alu_cin = carry register for op 1x, 0 for op 0x.
- RUN (each rising edge):
  - Write alu_z into result nibble idx.
  - Carry register := alu_cout.
  - If idx == NWORDS-1, go to DONE; else idx := idx+1.
- Outside RUN: alu_a, alu_b, alu_cin and alu_sop are driven to 0.
- Latency: out_valid is high exactly NWORDS+1 cycles after the accepting edge. Throughput is one op per NWORDS+2 cycles with out_ready held high.
- DONE:
  - out_z, out_cout and out_zero are stable.
  - out_cout = final carry register for op 1x, 0 for op 0x.
  - out_zero computed from out_z.
  - On out_ready, go to IDLE. Output registers hold their values until the next op writes them.
- Backpressure: while in DONE with out_ready=0, hold all outputs; in_ready stays 0. No bypass from DONE to RUN, so in_valid in DONE is ignored.
- Arithmetic semantics of the slice: op 10 computes a+b+cin; op 11 computes a+~b+cin. A caller performs A−B by setting in_cin=1; out_cout=1 then means no borrow.
- Changes to in_* after acceptance have no effect.
- NWORDS=1: RUN lasts one cycle.

Test Plan:
- ADD, in_a=0x1234, in_b=0x0FFF, in_cin=0 -> out_z=0x2233, out_cout=0, out_zero=0; out_valid exactly 5 cycles after accept (NWORDS=4).
- ADD, 0xFFFF + 0x0001, cin=0 -> out_z=0x0000, out_cout=1, out_zero=1. Check alu_cin=1 on slices 1–3.
- SUB, 0x0005 − 0x0003, cin=1 -> out_z=0x0002, out_cout=1. SUB, 0x0003 − 0x0005 -> out_z=0xFFFE, out_cout=0.
- NAND 0xF0F0, 0xFF00 -> out_z=0x0FFF, out_cout=0. NOR 0x00F0, 0x0F00 -> out_z=0xF00F. With in_cin=1 on both ops, alu_cin stays 0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_z/out_valid stable, in_ready=0, no second accept. Raise out_ready -> IDLE next edge, then the queued request is accepted.
- Reset mid-RUN: assert rst_n=0 at idx=2 -> next edge in_ready=1, out_valid=0, out_z=0. A fresh ADD 0x0001+0x0001 then yields 0x0002.
